mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 8K-word MEM between the IF-stage fetch requester and
//  the MA-stage load/store requester. Lets the pipelined core run from a unified
//  instruction/data memory. Data accesses normally win; a starvation counter
//  guarantees fetch progress. A requester's RDY low is its pipeline stall.
// PARAMETERS
//  AW          32  address width (word index taken from ADDR[14:2] by MEM)
//  DW          32  data width
//  MEM_LAT     1   cycles M_ADDR/M_WE held before M_DOUT is captured; legal 1..15
//  STARVE_MAX  4   max consecutive D grants while I_REQ is pending; legal 1..15
// PORTS
//  CLK      in   1   clock, rising edge
//  RST_X    in   1   asynchronous active-low reset
//  I_REQ    in   1   fetch request; hold with I_ADDR stable until I_RDY
//  I_ADDR   in   AW  fetch byte address
//  I_RDY    out  1   fetch accepted this cycle (combinational, IDLE only)
//  I_VLD    out  1   one-cycle pulse: I_DATA valid
//  I_DATA   out  DW  fetched word, held until next fetch response
//  D_REQ    in   1   data request; hold with D_WE/D_ADDR/D_WDATA stable until D_RDY
//  D_WE     in   1   1 = store, 0 = load
//  D_ADDR   in   AW  data byte address
//  D_WDATA  in   DW  store data
//  D_RDY    out  1   data accepted this cycle (combinational, IDLE only)
//  D_VLD    out  1   one-cycle pulse: load data valid / store complete
//  D_RDATA  out  DW  loaded word; unchanged by stores
//  M_ADDR   out  AW  memory address (registered)
//  M_DIN    out  DW  memory write data (registered)
//  M_WE     out  1   memory write enable (registered)
//  M_DOUT   in   DW  memory read data
//  BUSY     out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset (async, RST_X=0): state IDLE; all outputs 0 (RDY, VLD, DATA, M_*,
//   BUSY); starve counter 0. In-flight access dropped, no VLD issued, M_WE
//   falls immediately. First accept possible in the first cycle after release.
//  FSM: IDLE -> ACC -> RSP -> IDLE. Single outstanding access.
//   IDLE: if any REQ, pick winner; assert its RDY this cycle. On the edge, latch
//    owner, M_ADDR<=ADDR, M_DIN<=D_WDATA, M_WE<=(owner==D && D_WE), cnt<=MEM_LAT-1,
//    go ACC. No REQ: stay IDLE, M_WE=0.
//   ACC: M_WE high only in the first ACC cycle; M_ADDR/M_DIN held throughout.
//    cnt==0 on edge: capture M_DOUT into owner DATA (loads/fetches only), go RSP;
//    else cnt<=cnt-1.
//   RSP: owner VLD=1 for exactly this cycle; both RDY=0; next IDLE.
//  Latency: accept edge E0 -> VLD high in cycle after edge E0+MEM_LAT.
//   Throughput: one access per MEM_LAT+2 cycles. RDY=0 in ACC and RSP.
//  Arbitration (IDLE only): only one REQ -> it wins. Both REQ -> D wins unless
//   starve==STARVE_MAX, then I wins. starve+=1 on each D grant with I_REQ high
//   (saturates at STARVE_MAX); cleared on any I grant or any cycle I_REQ=0.
//  Never both RDY high; never both VLD high. REQ dropped before RDY: request
//   withdrawn, no access. REQ inputs ignored outside IDLE.
//  Width: starve and cnt are 4-bit; no address arithmetic in this block.
// TESTING
//  1 Reset: RST_X=0 mid-ACC of a store -> M_WE, BUSY, all VLD 0 immediately;
//    no D_VLD after release; mem word unchanged.
//  2 Fetch only: I_REQ, I_ADDR=0x8, mem[2]=0x20080005, MEM_LAT=1 -> I_RDY cycle
//    0, I_VLD cycle 2 with I_DATA=0x20080005; I_RDY next high cycle 3.
//  3 Store then load: D_WE=1 D_ADDR=0x40 D_WDATA=0xDEADBEEF, then load 0x40 ->
//    M_WE high exactly 1 cycle; load D_RDATA=0xDEADBEEF; D_RDATA unchanged at store VLD.
//  4 Contention: I_REQ and D_REQ held high, STARVE_MAX=4 -> grant sequence
//    D,D,D,D,I,D,D,D,D,I...; never both RDY.
//  5 MEM_LAT=3: single load -> M_ADDR held 3 cycles, D_VLD 4 cycles after the
//    accept edge, BUSY high 4 cycles.
//  6 Withdrawn request: D_REQ high during ACC of a fetch, dropped before IDLE ->
//    no D_RDY, no memory access, starve counter unaffected.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory signals of the unified-memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic          I_RDY;
    logic          I_VLD;
    logic [DW-1:0] I_DATA;
    logic          D_REQ;
    logic          D_WE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          D_RDY;
    logic          D_VLD;
    logic [DW-1:0] D_RDATA;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_DIN;
    logic          M_WE;
    logic [DW-1:0] M_DOUT;
    logic          BUSY;

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
        output I_RDY, I_VLD, I_DATA, D_RDY, D_VLD, D_RDATA, M_ADDR, M_DIN, M_WE, BUSY
    );

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
        input  I_RDY, I_VLD, I_DATA, D_RDY, D_VLD, D_RDATA, M_ADDR, M_DIN, M_WE, BUSY
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store requesters
// Data wins contention; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST_X,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RSP = 2'd2} state_t;

    localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state;
    state_t        state_nxt;
    logic          owner_d;
    logic          acc_rd;
    logic [3:0]    cnt;
    logic [3:0]    starve;
    logic          grant_i;
    logic          grant_d;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] rd_word;

    // RST_X gates the grants so both RDY read 0 while reset is held
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == S_IDLE && RST_X) begin
            grant_d = bus.D_REQ && (!bus.I_REQ || starve != STARVE_LIM);
            grant_i = bus.I_REQ && !grant_d;
        end
        sel_addr = grant_d ? bus.D_ADDR : bus.I_ADDR;
        rd_word  = bus.M_DOUT;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_i || grant_d) state_nxt = S_ACC;
            S_ACC:   if (cnt == 4'd0) state_nxt = S_RSP;
            S_RSP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.I_RDY = grant_i;
        bus.D_RDY = grant_d;
        bus.I_VLD = (state == S_RSP) && !owner_d;
        bus.D_VLD = (state == S_RSP) && owner_d;
        bus.BUSY  = (state != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            owner_d     <= 1'b0;
            acc_rd      <= 1'b0;
            cnt         <= 4'd0;
            starve      <= 4'd0;
            bus.M_ADDR  <= '0;
            bus.M_DIN   <= '0;
            bus.M_WE    <= 1'b0;
            bus.I_DATA  <= '0;
            bus.D_RDATA <= '0;
        end else begin
            // write strobe lives only in the first ACC cycle
            bus.M_WE <= 1'b0;
            if (grant_i || grant_d) begin
                owner_d    <= grant_d;
                acc_rd     <= !(grant_d && bus.D_WE);
                bus.M_ADDR <= sel_addr;
                bus.M_DIN  <= bus.D_WDATA;
                bus.M_WE   <= grant_d && bus.D_WE;
                cnt        <= LAT_M1;
            end
            if (state == S_ACC) begin
                if (cnt == 4'd0) begin
                    if (acc_rd && owner_d) begin
                        bus.D_RDATA <= rd_word;
                    end else if (acc_rd) begin
                        bus.I_DATA <= rd_word;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (grant_i || !bus.I_REQ) begin
                starve <= 4'd0;
            end else if (grant_d && starve != STARVE_LIM) begin
                starve <= starve + 4'd1;
            end
        end
    end
endmodule
